// File: rtl/priority_resolver_isr.sv
// Priority resolver and in-service register for an 8259-style interrupt controller.
// Arbitrates pending requests on a rotating priority ring, runs the two-ack INTA
// sequence, and retires in-service levels on EOI commands.
// Optional build macro PRIORITY_ROTATE_EN: a non-specific EOI makes the retired
// level the lowest priority. Without it, IR0 is always the highest priority.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | arbitrating; first INTA latches the winning level (or 7 if none)
// WAIT_ACK2 | first INTA taken; second INTA emits the vector, no arbitration
module priority_resolver_isr (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] risedBits,
    input  logic       interruptAck,
    input  logic       eoiValid,
    input  logic       eoiSpecific,
    input  logic [2:0] eoiLevel,
    input  logic [4:0] vectorBase,
    input  logic       readISR,
    output logic       INT,
    output logic       readPriority,
    output logic [2:0] resetIRR,
    output logic [7:0] vectorOut,
    output logic       vectorValid,
    output logic [7:0] isr,
    output logic [7:0] isrDataBuffer
);

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_ACK2 = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] highPri;
    logic [2:0] levelL;

    // Requests and in-service bits re-indexed so bit 0 is the highest-priority level.
    logic [7:0] reqRot;
    logic [7:0] isrRot;
    logic       winValid;
    logic       topValid;
    logic [2:0] winRank;
    logic [2:0] topRank;
    logic [2:0] winLevel;
    logic [2:0] topLevel;
    logic       winAbove;
    logic       ackFirst;
    logic [7:0] clearMask;
    logic [7:0] setMask;
    logic [7:0] isrNext;

    // Rotate onto the priority ring and pick the best-ranked request and in-service level.
    always_comb begin
        reqRot  = 8'h00;
        isrRot  = 8'h00;
        winRank = 3'd0;
        topRank = 3'd0;
        for (int i = 0; i < 8; i++) begin
            reqRot[i] = risedBits[3'(i) + highPri];
            isrRot[i] = isr[3'(i) + highPri];
        end
        for (int i = 7; i >= 0; i--) begin
            if (reqRot[i]) winRank = 3'(i);
            if (isrRot[i]) topRank = 3'(i);
        end
        winValid = |reqRot;
        topValid = |isrRot;
        winLevel = winRank + highPri;
        topLevel = topRank + highPri;
        winAbove = winValid && (!topValid || (winRank < topRank));
    end

    // EOI clear is applied before the first-ack set, so a same-bit collision keeps the bit set.
    always_comb begin
        ackFirst  = interruptAck && (state == IDLE);
        clearMask = 8'h00;
        setMask   = 8'h00;
        if (eoiValid) begin
            if (eoiSpecific)   clearMask = 8'b1 << eoiLevel;
            else if (topValid) clearMask = 8'b1 << topLevel;
        end
        if (ackFirst && winValid) setMask = 8'b1 << winLevel;
        isrNext = (isr & ~clearMask) | setMask;
    end

    // INTA sequencing, in-service register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            isr          <= 8'h00;
            INT          <= 1'b0;
            readPriority <= 1'b0;
            resetIRR     <= 3'd0;
            vectorOut    <= 8'h00;
            vectorValid  <= 1'b0;
            levelL       <= 3'd0;
        end else begin
            readPriority <= 1'b0;
            vectorValid  <= 1'b0;
            isr          <= isrNext;
            INT          <= (state == IDLE) && !interruptAck && winAbove;
            case (state)
                IDLE: begin
                    if (interruptAck) begin
                        state <= WAIT_ACK2;
                        if (winValid) begin
                            levelL       <= winLevel;
                            readPriority <= 1'b1;
                            resetIRR     <= winLevel;
                        end else begin
                            levelL <= 3'd7;
                        end
                    end
                end
                WAIT_ACK2: begin
                    if (interruptAck) begin
                        vectorOut   <= {vectorBase, levelL};
                        vectorValid <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRIORITY_ROTATE_EN
    // Automatic rotation: the level retired by a non-specific EOI becomes the lowest.
    always_ff @(posedge clk) begin
        if (reset) begin
            highPri <= 3'd0;
        end else if (eoiValid && !eoiSpecific && topValid) begin
            highPri <= topLevel + 3'd1;
        end
    end
`else
    assign highPri = 3'd0;
`endif

    assign isrDataBuffer = readISR ? isr : 8'bz;

endmodule

// File: tb/tb_priority_resolver_isr.sv
// Bench for priority_resolver_isr: directed vector table, hand-written rotation
// sequence, then randomized traffic against a ring-priority reference model.
// Honours PRIORITY_ROTATE_EN in the same way as the design.
module tb_priority_resolver_isr;

    logic       clk;
    logic       reset;
    logic [7:0] risedBits;
    logic       interruptAck;
    logic       eoiValid;
    logic       eoiSpecific;
    logic [2:0] eoiLevel;
    logic [4:0] vectorBase;
    logic       readISR;
    logic       INT;
    logic       readPriority;
    logic [2:0] resetIRR;
    logic [7:0] vectorOut;
    logic       vectorValid;
    logic [7:0] isr;
    logic [7:0] isrDataBuffer;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic       mInt;
    logic       mRp;
    logic [2:0] mRirr;
    logic [7:0] mVout;
    logic       mVv;
    logic [7:0] mIsr;
    logic [2:0] mL;
    logic       mWait;
    int         mHigh;

    priority_resolver_isr dut (
        .clk(clk),
        .reset(reset),
        .risedBits(risedBits),
        .interruptAck(interruptAck),
        .eoiValid(eoiValid),
        .eoiSpecific(eoiSpecific),
        .eoiLevel(eoiLevel),
        .vectorBase(vectorBase),
        .readISR(readISR),
        .INT(INT),
        .readPriority(readPriority),
        .resetIRR(resetIRR),
        .vectorOut(vectorOut),
        .vectorValid(vectorValid),
        .isr(isr),
        .isrDataBuffer(isrDataBuffer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] rb;
        logic       ack;
        logic       ev;
        logic       es;
        logic [2:0] el;
        logic       xInt;
        logic       xRp;
        logic [2:0] xRirr;
        logic [7:0] xIsr;
        logic [7:0] xVout;
        logic       xVv;
    } vec_t;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: walk the ring from the current highest level.
    task automatic modelStep();
        int w, wr, t, tr, lvl;
        logic [7:0] nIsr;
        w = -1; wr = 8; t = -1; tr = 8;
        for (int k = 0; k < 8; k++) begin
            lvl = (mHigh + k) % 8;
            if (w < 0 && risedBits[lvl]) begin w = lvl; wr = k; end
            if (t < 0 && mIsr[lvl]) begin t = lvl; tr = k; end
        end
        if (reset) begin
            mInt = 0; mRp = 0; mRirr = 0; mVout = 0; mVv = 0;
            mIsr = 0; mL = 0; mWait = 0; mHigh = 0;
        end else begin
            nIsr = mIsr;
            mInt = !mWait && !interruptAck && (w >= 0) && (t < 0 || wr < tr);
            mRp  = 0;
            mVv  = 0;
            if (eoiValid) begin
                if (eoiSpecific) nIsr[eoiLevel] = 1'b0;
                else if (t >= 0) begin
                    nIsr[t] = 1'b0;
`ifdef PRIORITY_ROTATE_EN
                    mHigh = (t + 1) % 8;
`endif
                end
            end
            if (interruptAck) begin
                if (!mWait) begin
                    if (w >= 0) begin
                        nIsr[w] = 1'b1;
                        mL      = 3'(w);
                        mRp     = 1;
                        mRirr   = 3'(w);
                    end else begin
                        mL = 3'd7;
                    end
                    mWait = 1;
                end else begin
                    mVout = {vectorBase, mL};
                    mVv   = 1;
                    mWait = 0;
                end
            end
            mIsr = nIsr;
        end
    endtask

    task automatic step();
        @(posedge clk);
        modelStep();
        #1;
        chk("model_INT", {7'b0, INT}, {7'b0, mInt});
        chk("model_readPriority", {7'b0, readPriority}, {7'b0, mRp});
        chk("model_resetIRR", {5'b0, resetIRR}, {5'b0, mRirr});
        chk("model_vectorOut", vectorOut, mVout);
        chk("model_vectorValid", {7'b0, vectorValid}, {7'b0, mVv});
        chk("model_isr", isr, mIsr);
        chk("model_isrDataBuffer", isrDataBuffer, readISR ? mIsr : 8'bz);
    endtask

    task automatic drive(input logic rst, input logic [7:0] rb, input logic ack,
                         input logic ev, input logic es, input logic [2:0] el);
        reset = rst; risedBits = rb; interruptAck = ack;
        eoiValid = ev; eoiSpecific = es; eoiLevel = el;
    endtask

    function automatic vec_t mk(input logic rst, input logic [7:0] rb, input logic ack,
                                input logic ev, input logic es, input logic [2:0] el,
                                input logic xi, input logic xr, input logic [2:0] xrirr,
                                input logic [7:0] xisr, input logic [7:0] xvo, input logic xvv);
        vec_t v;
        v.rst = rst; v.rb = rb; v.ack = ack; v.ev = ev; v.es = es; v.el = el;
        v.xInt = xi; v.xRp = xr; v.xRirr = xrirr; v.xIsr = xisr; v.xVout = xvo; v.xVv = xvv;
        return v;
    endfunction

    vec_t tbl[22];

    initial begin
        mInt = 0; mRp = 0; mRirr = 0; mVout = 0; mVv = 0;
        mIsr = 0; mL = 0; mWait = 0; mHigh = 0;
        vectorBase = 5'h08;
        readISR    = 1'b1;
        drive(1, 8'h00, 0, 0, 0, 3'd0);

        //            rst rb     ack ev es el    INT rp rirr isr    vout   vv
        tbl[0]  = mk(1, 8'h00, 0, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00, 8'h00, 0);
        tbl[1]  = mk(0, 8'h28, 0, 0, 0, 3'd0, 1, 0, 3'd0, 8'h00, 8'h00, 0);
        tbl[2]  = mk(0, 8'h28, 1, 0, 0, 3'd0, 0, 1, 3'd3, 8'h08, 8'h00, 0);
        tbl[3]  = mk(0, 8'h20, 0, 0, 0, 3'd0, 0, 0, 3'd3, 8'h08, 8'h00, 0);
        tbl[4]  = mk(0, 8'h20, 1, 0, 0, 3'd0, 0, 0, 3'd3, 8'h08, 8'h43, 1);
        tbl[5]  = mk(0, 8'h20, 0, 0, 0, 3'd0, 0, 0, 3'd3, 8'h08, 8'h43, 0);
        tbl[6]  = mk(0, 8'h02, 0, 0, 0, 3'd0, 1, 0, 3'd3, 8'h08, 8'h43, 0);
        tbl[7]  = mk(0, 8'h02, 1, 0, 0, 3'd0, 0, 1, 3'd1, 8'h0A, 8'h43, 0);
        tbl[8]  = mk(0, 8'h00, 1, 0, 0, 3'd0, 0, 0, 3'd1, 8'h0A, 8'h41, 1);
        tbl[9]  = mk(0, 8'h00, 0, 1, 0, 3'd0, 0, 0, 3'd1, 8'h08, 8'h41, 0);
        tbl[10] = mk(0, 8'h00, 0, 1, 1, 3'd5, 0, 0, 3'd1, 8'h08, 8'h41, 0);
        tbl[11] = mk(0, 8'h00, 0, 1, 1, 3'd3, 0, 0, 3'd1, 8'h00, 8'h41, 0);
        tbl[12] = mk(1, 8'h00, 0, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00, 8'h00, 0);
        tbl[13] = mk(0, 8'h00, 1, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00, 8'h00, 0);
        tbl[14] = mk(0, 8'h00, 1, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00, 8'h47, 1);
        tbl[15] = mk(0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00, 8'h47, 0);
        tbl[16] = mk(0, 8'h10, 0, 0, 0, 3'd0, 1, 0, 3'd0, 8'h00, 8'h47, 0);
        tbl[17] = mk(0, 8'h10, 1, 0, 0, 3'd0, 0, 1, 3'd4, 8'h10, 8'h47, 0);
        tbl[18] = mk(1, 8'h10, 0, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00, 8'h00, 0);
        tbl[19] = mk(0, 8'h00, 1, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00, 8'h00, 0);
        tbl[20] = mk(0, 8'h00, 0, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00, 8'h00, 0);
        tbl[21] = mk(1, 8'h00, 0, 0, 0, 3'd0, 0, 0, 3'd0, 8'h00, 8'h00, 0);

        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].rst, tbl[i].rb, tbl[i].ack, tbl[i].ev, tbl[i].es, tbl[i].el);
            step();
            chk($sformatf("tbl%0d_INT", i), {7'b0, INT}, {7'b0, tbl[i].xInt});
            chk($sformatf("tbl%0d_readPriority", i), {7'b0, readPriority}, {7'b0, tbl[i].xRp});
            chk($sformatf("tbl%0d_resetIRR", i), {5'b0, resetIRR}, {5'b0, tbl[i].xRirr});
            chk($sformatf("tbl%0d_isr", i), isr, tbl[i].xIsr);
            chk($sformatf("tbl%0d_isrDataBuffer", i), isrDataBuffer, tbl[i].xIsr);
            chk($sformatf("tbl%0d_vectorOut", i), vectorOut, tbl[i].xVout);
            chk($sformatf("tbl%0d_vectorValid", i), {7'b0, vectorValid}, {7'b0, tbl[i].xVv});
        end

        // Rotation sequence: service IR2, retire it with a non-specific EOI.
        drive(0, 8'h04, 0, 0, 0, 3'd0); step();
        chk("rot_int_ir2", {7'b0, INT}, 8'h01);
        drive(0, 8'h04, 1, 0, 0, 3'd0); step();
        chk("rot_rirr_ir2", {5'b0, resetIRR}, 8'h02);
        chk("rot_isr_ir2", isr, 8'h04);
        drive(0, 8'h00, 1, 0, 0, 3'd0); step();
        chk("rot_vec_ir2", vectorOut, 8'h42);
        drive(0, 8'h00, 0, 1, 0, 3'd0); step();
        chk("rot_isr_cleared", isr, 8'h00);
        drive(0, 8'h05, 0, 0, 0, 3'd0); step();
        drive(0, 8'h05, 1, 0, 0, 3'd0); step();
        chk("rot_rirr_0x05", {5'b0, resetIRR}, 8'h00);
        drive(0, 8'h04, 1, 0, 0, 3'd0); step();
        chk("rot_vec_0x05", vectorOut, 8'h40);
        drive(0, 8'h04, 0, 1, 1, 3'd0); step();
        chk("rot_isr_spec0", isr, 8'h00);
        drive(0, 8'h09, 0, 0, 0, 3'd0); step();
        drive(0, 8'h09, 1, 0, 0, 3'd0); step();
`ifdef PRIORITY_ROTATE_EN
        chk("rot_rirr_0x09", {5'b0, resetIRR}, 8'h03);
`else
        chk("rot_rirr_0x09", {5'b0, resetIRR}, 8'h00);
`endif
        drive(0, 8'h00, 1, 0, 0, 3'd0); step();
`ifdef PRIORITY_ROTATE_EN
        chk("rot_vec_0x09", vectorOut, 8'h43);
`else
        chk("rot_vec_0x09", vectorOut, 8'h40);
`endif

        // Randomized traffic against the model.
        drive(1, 8'h00, 0, 0, 0, 3'd0); step();
        for (int n = 0; n < 800; n++) begin
            reset        = ($urandom_range(0, 79) == 0);
            risedBits    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            interruptAck = ($urandom_range(0, 3) == 0);
            eoiValid     = ($urandom_range(0, 4) == 0);
            eoiSpecific  = 1'($urandom);
            eoiLevel     = 3'($urandom);
            readISR      = 1'($urandom);
            if ($urandom_range(0, 15) == 0) vectorBase = 5'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
